// File: rtl/bids_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// bids_cmd_sequencer
//
// Command sequencer sitting in front of the bids22 auction controller.
// Host commands are buffered in a small FIFO and replayed one at a time onto
// the auction's controller inputs (c_op / c_data / c_start). A pop only
// happens while the auction reports ready.
//
// Two kinds of command exist:
//   * RUNROUND (cmd_op all-ones): hold c_start high for max(cmd_data, 1)
//     cycles, then wait for roundOver and capture maxBid for the host.
//   * anything else: passed through unchanged as a one-cycle c_op/c_data
//     issue. Opcode legality is the auction's business; it reports problems
//     back through a_err.
//
// Auction errors seen while issuing or running a round are captured
// (first-error-wins) into a sticky err_flag / err_code pair.
//
// Optional feature, macro BIDS_SEQ_TIMEOUT_EN:
//   When defined, a round that sees no roundOver within ROUND_TIMEOUT cycles
//   of WAITOVER is abandoned, flagged with err_code all-ones and no result
//   pulse. When undefined, WAITOVER waits indefinitely and no counter exists.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          host push handshake (cmd_ready = FIFO not full)
//   cmd_op, cmd_data             command opcode and operand
//   c_op, c_data, c_start        auction controller inputs
//   a_ready, a_err               auction ready and error code
//   a_round_over, a_max_bid      auction round completion and winning bid
//   res_valid, res_max_bid       one-cycle result pulse and last captured bid
//   err_flag, err_code, err_clear sticky error capture and its clear
//   busy                         FSM not idle or FIFO holds commands
// ---------------------------------------------------------------------------
module bids_cmd_sequencer #(
  parameter int DATAWIDTH     = 32,
  parameter int OPWIDTH       = 4,
  parameter int ERRWIDTH      = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter int ROUND_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OPWIDTH-1:0]   cmd_op,
  input  logic [DATAWIDTH-1:0] cmd_data,
  output logic [OPWIDTH-1:0]   c_op,
  output logic [DATAWIDTH-1:0] c_data,
  output logic                 c_start,
  input  logic                 a_ready,
  input  logic [ERRWIDTH-1:0]  a_err,
  input  logic                 a_round_over,
  input  logic [DATAWIDTH-1:0] a_max_bid,
  output logic                 res_valid,
  output logic [DATAWIDTH-1:0] res_max_bid,
  output logic                 err_flag,
  output logic [ERRWIDTH-1:0]  err_code,
  input  logic                 err_clear,
  output logic                 busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [OPWIDTH-1:0] OP_RUNROUND = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_ROUND,
    S_WAITOVER
  } state_t;

  state_t state_q, state_d;

  // -------------------------------------------------------------------------
  // Command FIFO. Pointers carry one extra bit so full and empty can be told
  // apart when the index bits match.
  // -------------------------------------------------------------------------
  logic [OPWIDTH-1:0]   fifo_op   [FIFO_DEPTH];
  logic [DATAWIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 fifo_empty, fifo_full;
  logic                 push, pop;
  logic [OPWIDTH-1:0]   head_op;
  logic [DATAWIDTH-1:0] head_data;
  logic                 head_is_round;

  assign fifo_empty    = (wr_ptr == rd_ptr);
  assign fifo_full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                         (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready     = !fifo_full;
  assign push          = cmd_valid && cmd_ready;
  assign head_op       = fifo_op[rd_ptr[AW-1:0]];
  assign head_data     = fifo_data[rd_ptr[AW-1:0]];
  assign head_is_round = (head_op == OP_RUNROUND);

  // NOTE: storage arrays are deliberately left out of reset; the pointers
  // define which entries are meaningful, and unreset RAM maps to plain
  // memory cells instead of a wide bank of resettable flops.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr[AW-1:0]]   <= cmd_op;
      fifo_data[wr_ptr[AW-1:0]] <= cmd_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Latched command / round bookkeeping
  // -------------------------------------------------------------------------
  logic [OPWIDTH-1:0]   issue_op;
  logic [DATAWIDTH-1:0] issue_data;
  logic [DATAWIDTH-1:0] round_cnt;
  logic                 capture;
  logic                 timeout_hit;
  logic                 err_hit;
  logic [ERRWIDTH-1:0]  err_val;

`ifdef BIDS_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(ROUND_TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;

  // Cycles spent in WAITOVER so far; restarts on every entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  wait_cnt <= '0;
    else if (state_q != S_WAITOVER) wait_cnt <= '0;
    else                            wait_cnt <= wait_cnt + 1'b1;
  end
`else
  // The timeout length only matters when the timeout logic is built in.
  localparam int unused_round_timeout = ROUND_TIMEOUT;
`endif

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    c_op        = '0;
    c_data      = '0;
    c_start     = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    err_hit     = 1'b0;
    err_val     = a_err;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && a_ready) begin
          pop     = 1'b1;
          state_d = head_is_round ? S_ROUND : S_ISSUE;
        end
      end
      S_ISSUE: begin
        c_op    = issue_op;
        c_data  = issue_data;
        state_d = S_IDLE;
      end
      S_ROUND: begin
        c_start = 1'b1;
        // round_cnt is the number of c_start cycles still owed, this one
        // included.
        if (round_cnt == DATAWIDTH'(1)) state_d = S_WAITOVER;
      end
      S_WAITOVER: begin
        if (a_round_over) begin
          capture = 1'b1;
          state_d = S_IDLE;
        end
`ifdef BIDS_SEQ_TIMEOUT_EN
        else if (wait_cnt == TW'(ROUND_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Auction errors only mean something while we are driving it.
    if ((state_q == S_ISSUE || state_q == S_ROUND) && (a_err != '0)) begin
      err_hit = 1'b1;
    end
    if (timeout_hit) begin
      err_hit = 1'b1;
      err_val = '1;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_op    <= '0;
      issue_data  <= '0;
      round_cnt   <= '0;
      res_valid   <= 1'b0;
      res_max_bid <= '0;
      err_flag    <= 1'b0;
      err_code    <= '0;
    end else begin
      res_valid <= 1'b0;

      if (pop && !head_is_round) begin
        issue_op   <= head_op;
        issue_data <= head_data;
      end

      // A zero-length round is stretched to one cycle of c_start.
      if (pop && head_is_round) begin
        round_cnt <= (head_data == '0) ? DATAWIDTH'(1) : head_data;
      end else if (state_q == S_ROUND) begin
        round_cnt <= round_cnt - 1'b1;
      end

      if (capture) begin
        res_max_bid <= a_max_bid;
        res_valid   <= 1'b1;
      end

      // First error wins; a clear in the same cycle as a new error lets the
      // new error through.
      if (err_hit && (!err_flag || err_clear)) begin
        err_flag <= 1'b1;
        err_code <= err_val;
      end else if (err_clear) begin
        err_flag <= 1'b0;
        err_code <= '0;
      end
    end
  end

  assign busy = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_bids_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bids_cmd_sequencer
//
// Self-checking bench for bids_cmd_sequencer. A monitor process compares
// issued commands, c_start run lengths and round results against queues of
// expected values filled when the stimulus is pushed. Directed checks cover
// reset values, issue latency, FIFO-full back-pressure, error capture and the
// WAITOVER behaviour with and without BIDS_SEQ_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_bids_cmd_sequencer;

  localparam int DW = 32;
  localparam int OW = 4;
  localparam int EW = 3;
  localparam logic [OW-1:0] RUNROUND = 4'hF;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [OW-1:0] cmd_op;
  logic [DW-1:0] cmd_data;
  logic [OW-1:0] c_op;
  logic [DW-1:0] c_data;
  logic          c_start;
  logic          a_ready;
  logic [EW-1:0] a_err;
  logic          a_round_over;
  logic [DW-1:0] a_max_bid;
  logic          res_valid;
  logic [DW-1:0] res_max_bid;
  logic          err_flag;
  logic [EW-1:0] err_code;
  logic          err_clear;
  logic          busy;

  always #5 clk = ~clk;

  bids_cmd_sequencer #(
    .DATAWIDTH(DW), .OPWIDTH(OW), .ERRWIDTH(EW),
    .FIFO_DEPTH(4), .ROUND_TIMEOUT(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .c_op(c_op), .c_data(c_data), .c_start(c_start),
    .a_ready(a_ready), .a_err(a_err),
    .a_round_over(a_round_over), .a_max_bid(a_max_bid),
    .res_valid(res_valid), .res_max_bid(res_max_bid),
    .err_flag(err_flag), .err_code(err_code), .err_clear(err_clear),
    .busy(busy)
  );

  typedef struct {
    logic [OW-1:0] op;
    logic [DW-1:0] data;
  } cmd_t;

  cmd_t          exp_issue [$];
  int            exp_len   [$];
  logic [DW-1:0] exp_res   [$];
  int            issue_cyc [$];
  int            cyc;
  int            run_len;
  cmd_t          mon_e;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Main-thread step: one clock later, just after the monitor has sampled.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Push one command; expected outcomes go to the scoreboard when record=1.
  task automatic push(input logic [OW-1:0] op, input logic [DW-1:0] data,
                      input bit record);
    int n;
    cmd_t e;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    check("push_ready_wait", n < 50, 1'b1);
    if (record) begin
      if (op == RUNROUND) begin
        exp_len.push_back((data == 0) ? 1 : int'(data));
      end else begin
        e.op   = op;
        e.data = data;
        exp_issue.push_back(e);
      end
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_issues_drained();
    int n = 0;
    while (exp_issue.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check("issue_drain_timeout", exp_issue.size(), 0);
  endtask

  task automatic wait_round_started();
    int n = 0;
    while (!c_start && n < 50) begin
      step();
      n++;
    end
    check("round_start_timeout", c_start, 1'b1);
  endtask

  task automatic wait_round_ended();
    int n = 0;
    while (exp_len.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check("round_end_timeout", exp_len.size(), 0);
  endtask

  // Called in WAITOVER: report roundOver with the given bid.
  task automatic finish_round(input logic [DW-1:0] bid);
    int n = 0;
    a_max_bid    = bid;
    a_round_over = 1'b1;
    exp_res.push_back(bid);
    step();
    a_round_over = 1'b0;
    a_max_bid    = '0;
    while (exp_res.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check("result_timeout", exp_res.size(), 0);
    step();
    check("res_max_bid_hold", res_max_bid, bid);
    check("idle_after_round", busy, 1'b0);
  endtask

  initial begin
    int nz;

    reset_n      = 1'b0;
    cmd_valid    = 1'b0;
    cmd_op       = '0;
    cmd_data     = '0;
    a_ready      = 1'b1;
    a_err        = '0;
    a_round_over = 1'b0;
    a_max_bid    = '0;
    err_clear    = 1'b0;
    cyc          = 0;
    run_len      = 0;

    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (!reset_n) begin
          run_len = 0;
        end else begin
          if (c_op != '0 || c_data != '0) begin
            issue_cyc.push_back(cyc);
            if (exp_issue.size() == 0) begin
              check("unexpected_issue", c_op, 0);
            end else begin
              mon_e = exp_issue.pop_front();
              check("issue_op", c_op, mon_e.op);
              check("issue_data", c_data, mon_e.data);
            end
          end
          if (c_start) begin
            run_len++;
          end else if (run_len > 0) begin
            if (exp_len.size() == 0) check("unexpected_round", run_len, 0);
            else                     check("c_start_len", run_len, exp_len.pop_front());
            run_len = 0;
          end
          if (res_valid) begin
            if (exp_res.size() == 0) check("unexpected_res_valid", res_valid, 1'b0);
            else                     check("res_max_bid", res_max_bid, exp_res.pop_front());
          end
        end
      end
    join_none

    // ---- Reset values -----------------------------------------------------
    repeat (3) step();
    check("rst_c_op", c_op, 0);
    check("rst_c_data", c_data, 0);
    check("rst_c_start", c_start, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_max_bid", res_max_bid, 0);
    check("rst_err_flag", err_flag, 0);
    check("rst_err_code", err_code, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    reset_n = 1'b1;
    step();

    // ---- Single LOCK: issue latency and one-cycle width -------------------
    push(4'd2, 32'h55, 1'b1);
    check("lock_not_yet", c_op, 0);
    step();
    check("lock_op", c_op, 2);
    check("lock_data", c_data, 32'h55);
    step();
    check("lock_gone_op", c_op, 0);
    check("lock_gone_data", c_data, 0);
    wait_issues_drained();

    // ---- FIFO fill with a_ready low, then drain ----------------------------
    a_ready = 1'b0;
    push(4'd3, 32'd100, 1'b1);
    push(4'd4, 32'd200, 1'b1);
    push(4'd5, 32'd300, 1'b1);
    push(4'd6, 32'd7,   1'b1);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_busy", busy, 1);
    nz = 0;
    repeat (5) begin
      step();
      if (c_op != '0) nz++;
    end
    check("no_issue_while_not_ready", nz, 0);
    issue_cyc.delete();
    a_ready = 1'b1;
    wait_issues_drained();
    check("drain_issue_count", issue_cyc.size(), 4);
    if (issue_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) begin
        check("issue_spacing", issue_cyc[i] - issue_cyc[i-1], 2);
      end
    end
    step();
    check("drained_cmd_ready", cmd_ready, 1);
    check("drained_busy", busy, 0);

    // ---- Rounds -------------------------------------------------------------
    push(RUNROUND, 32'd5, 1'b1);
    wait_round_ended();
    check("waitover_busy", busy, 1);
    finish_round(32'd42);

    push(RUNROUND, 32'd0, 1'b1);
    wait_round_ended();
    finish_round(32'd99);

    // ---- Error capture during a round --------------------------------------
    push(RUNROUND, 32'd10, 1'b1);
    wait_round_started();
    a_err = 3'd3;
    step();
    a_err = 3'd5;
    step();
    a_err = 3'd0;
    check("err_flag_first", err_flag, 1);
    check("err_code_first_wins", err_code, 3);
    a_err     = 3'd5;
    err_clear = 1'b1;
    step();
    a_err     = 3'd0;
    err_clear = 1'b0;
    check("err_clear_new_wins_flag", err_flag, 1);
    check("err_clear_new_wins_code", err_code, 5);
    wait_round_ended();
    finish_round(32'd7);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("err_cleared_flag", err_flag, 0);
    check("err_cleared_code", err_code, 0);
    a_err = 3'd6;
    repeat (2) step();
    a_err = 3'd0;
    check("err_ignored_in_idle", err_flag, 0);

    // ---- WAITOVER without roundOver ------------------------------------------
    push(RUNROUND, 32'd2, 1'b1);
    wait_round_ended();
`ifdef BIDS_SEQ_TIMEOUT_EN
    repeat (15) step();
    check("timeout_not_early_busy", busy, 1);
    check("timeout_not_early_err", err_flag, 0);
    step();
    check("timeout_idle", busy, 0);
    check("timeout_err_flag", err_flag, 1);
    check("timeout_err_code", err_code, 7);
    repeat (3) step();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
`else
    repeat (30) step();
    check("waitover_forever_busy", busy, 1);
    check("waitover_forever_start", c_start, 0);
    check("waitover_forever_res", res_valid, 0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
`endif

    // ---- Asynchronous reset in the middle of a round ------------------------
    push(RUNROUND, 32'd20, 1'b0);
    wait_round_started();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_c_start", c_start, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_cmd_ready", cmd_ready, 1);
    check("async_rst_err_flag", err_flag, 0);
    step();
    reset_n = 1'b1;
    step();

    // ---- Recovery after reset -----------------------------------------------
    push(4'd7, 32'h1234, 1'b1);
    wait_issues_drained();
    repeat (3) step();
    check("final_issue_queue", exp_issue.size(), 0);
    check("final_len_queue", exp_len.size(), 0);
    check("final_res_queue", exp_res.size(), 0);
    check("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bids_cmd_sequencer.md
# bids_cmd_sequencer

Command sequencer upstream of the bids22 auction FSM. It buffers host commands in a small FIFO and replays them onto the auction's controller inputs (C_op, C_data, C_start), honouring the auction's ready. It also times bid rounds by holding C_start for a programmed number of cycles, then captures the round result (maxBid) and any controller error for the host.

## Interface
Parameters:
- DATAWIDTH, 32, width of command data, C_data and maxBid
- OPWIDTH, 4, width of opcodes (auction encoding: 0 NO_OP, 1 UNLOCK, 2 LOCK, 3 LOADX, 4 LOADY, 5 LOADZ, 6 SETMASK, 7 SETTIMER, 8 SETBIDCHARGE)
- ERRWIDTH, 3, width of auction controller error code; 0 = no error
- FIFO_DEPTH, 4, command FIFO entries, power of two ≥ 2
- ROUND_TIMEOUT, 16, max cycles to wait for roundOver (only with macro)

Ports (reset reset_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  FIFO not full; a push occurs when cmd_valid && cmd_ready
- cmd_op  in  OPWIDTH  opcode; all-ones (4'hF) = RUNROUND, others passed through
- cmd_data  in  DATAWIDTH  operand; for RUNROUND, the round length in cycles
- c_op  out  OPWIDTH  to auction C_op
- c_data  out  DATAWIDTH  to auction C_data
- c_start  out  1  to auction C_start
- a_ready  in  1  auction cout.ready
- a_err  in  ERRWIDTH  auction cout.err
- a_round_over  in  1  auction cout.roundOver
- a_max_bid  in  DATAWIDTH  auction cout.maxBid
- res_valid  out  1  one-cycle pulse: round result captured
- res_max_bid  out  DATAWIDTH  last captured maxBid
- err_flag  out  1  sticky: an auction error was seen
- err_code  out  ERRWIDTH  first error code captured since the last clear
- err_clear  in  1  clears err_flag and err_code
- busy  out  1  FSM not in IDLE, or FIFO non-empty

## Operation
- FIFO: FIFO_DEPTH entries of {op, data}, with wrap-around read/write pointers plus an extra pointer bit for full/empty. A push while full is impossible because cmd_ready is 0. Popping while empty never occurs.
- FSM states: IDLE, ISSUE, ROUND, WAITOVER.
- IDLE:
  - If the FIFO is non-empty and a_ready = 1, pop the head entry.
  - If op ≠ RUNROUND, latch op/data and go to ISSUE.
  - If op = RUNROUND, load round_cnt = max(data, 1) and go to ROUND.
- ISSUE: drive c_op/c_data from the latched entry for exactly one cycle, then return to IDLE.
- ROUND:
  - c_start = 1 and round_cnt decrements each cycle.
  - When round_cnt = 1, go to WAITOVER. C_start is therefore high for exactly max(data, 1) cycles.
- WAITOVER:
  - c_start = 0.
  - On a_round_over = 1, capture a_max_bid into res_max_bid, pulse res_valid, and go to IDLE.
- Outside ISSUE, c_op = 0 (NO_OP) and c_data = 0. c_start = 1 only in ROUND.
- Error capture:
  - Sampled every cycle in ISSUE and ROUND.
  - If a_err ≠ 0 and err_flag = 0, set err_flag = 1 and err_code = a_err.
  - Later errors do not overwrite err_code.
  - err_clear clears both fields. If a new error arrives in the same cycle as err_clear, the new error wins and is captured.
- The sequencer does not interpret opcodes beyond RUNROUND. Lock/unlock legality is the auction's job, and is reported back through a_err.

## Timing
- Reset values: c_op 0, c_data 0, c_start 0, res_valid 0, res_max_bid 0, err_flag 0, err_code 0, busy 0, cmd_ready 1. FIFO is emptied and the FSM goes to IDLE.
- Reset mid-round deasserts c_start asynchronously.
- Push-to-issue latency on an empty FIFO with a_ready = 1: the command is pushed at edge N, popped at edge N+1, and c_op is valid in the cycle after edge N+1.
- Back-to-back non-round commands issue every 2 cycles (IDLE, ISSUE).
- A push and a pop in the same cycle leave the FIFO count unchanged.
- cmd_ready is combinational from the FIFO count only.
- res_valid is high for exactly one cycle, the cycle after a_round_over is sampled.

## Configuration
- BIDS_SEQ_TIMEOUT_EN defined:
  - WAITOVER counts cycles. If a_round_over has not been seen after ROUND_TIMEOUT cycles, set err_flag = 1 and err_code = all-ones (if not already set), return to IDLE, and do not pulse res_valid.
- BIDS_SEQ_TIMEOUT_EN undefined: WAITOVER waits indefinitely and no timeout counter exists.

## Test plan
- Reset, then push LOCK (op 2, data 0x55) → c_op = 2 and c_data = 0x55 for exactly one cycle, 2 cycles after the push. Otherwise c_op = 0.
- Push LOADX 100, LOADY 200, LOADZ 300, SETMASK 7 back-to-back, with a_ready held at 0 → cmd_ready = 0 after 4 pushes and no issue occurs. Raise a_ready → four one-cycle issues, in order, 2 cycles apart.
- Push RUNROUND with data 5 → c_start high for exactly 5 cycles. Drive a_round_over = 1 with a_max_bid = 42 → res_valid pulses once and res_max_bid = 42.
- Push RUNROUND with data 0 → c_start high for exactly 1 cycle.
- During ROUND, drive a_err = 3, then a_err = 5 → err_code = 3 and err_flag = 1. Assert err_clear together with a_err = 5 → err_code = 5.
- With BIDS_SEQ_TIMEOUT_EN defined and ROUND_TIMEOUT = 16, never assert a_round_over → after 16 cycles in WAITOVER, err_code = 7, FSM returns to IDLE and there is no res_valid. Without the macro, busy stays 1.
